vote_session: RTL and testbench

Parametrised, clocked successor to the combinational 4-input voter. It runs one ballot session for `N_VOTERS` voters. Each voter may cast exactly one yes/no vote while the session is open. The session closes when every voter has voted, when `close` is asserted, or when a cycle timeout expires. It then publishes a held one-hot verdict with the same encoding as the existing voter: reject / tie / pass.

---
 rtl/vote_session.sv | 101 ++++++++++
 tb/tb_vote_session.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/vote_session.sv
// Single-session N-voter ballot with early close and cycle timeout, held one-hot verdict.
// Latency: votes visible one cycle after sampling; verdict two cycles after the close condition.
// No backpressure: votes outside OPEN and repeat votes are dropped.
module vote_session #(
    parameter int N_VOTERS = 4,
    parameter int TIMEOUT  = 1000,
    localparam int CW      = $clog2(N_VOTERS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                close,
    input  logic [N_VOTERS-1:0] vote_valid,
    input  logic [N_VOTERS-1:0] vote_yes,
    output logic [N_VOTERS-1:0] voted,
    output logic [CW-1:0]       yes_count,
    output logic                busy,
    output logic [2:0]          result,
    output logic                result_valid,
    output logic                done
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    localparam logic [CW:0]   N_W  = (CW+1)'(N_VOTERS);

    typedef enum logic [1:0] {S_IDLE, S_OPEN, S_EVAL, S_RESULT} state_t;

    state_t              state, state_nxt;
    logic [TW-1:0]       timer;
    logic [N_VOTERS-1:0] accept;
    logic [CW-1:0]       add_cnt;
    logic                close_now;
    logic [CW:0]         twice_y;
    logic [2:0]          verdict;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        accept    = '0;
        add_cnt   = '0;
        close_now = 1'b0;
        state_nxt = state;
        if (state == S_OPEN) accept = vote_valid & ~voted;
        for (int i = 0; i < N_VOTERS; i++)
            add_cnt = add_cnt + CW'(accept[i] & vote_yes[i]);
        // votes landing in the closing cycle still count toward the all-voted test
        close_now = (&(voted | accept)) || close || (timer == TMAX);
        case (state)
            S_IDLE:   if (start) state_nxt = S_OPEN;
            S_OPEN:   if (close_now) state_nxt = S_EVAL;
            S_EVAL:   state_nxt = S_RESULT;
            S_RESULT: if (start) state_nxt = S_OPEN;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        twice_y = {yes_count, 1'b0};
        if (twice_y < N_W)       verdict = 3'b100;
        else if (twice_y == N_W) verdict = 3'b010;
        else                     verdict = 3'b001;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            voted     <= '0;
            yes_count <= '0;
            timer     <= '0;
            result    <= 3'b000;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_RESULT: begin
                    if (start) begin
                        voted     <= '0;
                        yes_count <= '0;
                        timer     <= '0;
                        result    <= 3'b000;
                    end
                end
                S_OPEN: begin
                    voted     <= voted | accept;
                    yes_count <= yes_count + add_cnt;
                    timer     <= timer + 1'b1;
                end
                S_EVAL: begin
                    result <= verdict;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state == S_OPEN) || (state == S_EVAL);
    assign result_valid = (state == S_RESULT);
endmodule

// File: tb/tb_vote_session.sv
// Directed test-plan sessions followed by random traffic, all checked every cycle against a ballot model.
module tb_vote_session;
    localparam int N  = 4;
    localparam int TO = 16;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst, start, close;
    logic [N-1:0]  vote_valid, vote_yes;
    logic [N-1:0]  voted;
    logic [CW-1:0] yes_count;
    logic          busy, result_valid, done;
    logic [2:0]    result;

    int n_tests = 0;
    int n_fail  = 0;

    // ballot model: phase 0 idle, 1 open, 2 evaluating, 3 result published
    int       m_phase = 0;
    bit [N-1:0] m_voted = '0;
    int       m_yes = 0;
    int       m_open = 0;
    bit       m_done = 1'b0;
    bit [2:0] m_result = 3'b000;

    vote_session #(.N_VOTERS(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .close(close),
        .vote_valid(vote_valid), .vote_yes(vote_yes),
        .voted(voted), .yes_count(yes_count), .busy(busy),
        .result(result), .result_valid(result_valid), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit c,
                              input bit [N-1:0] vv, input bit [N-1:0] vy);
        m_done = 1'b0;
        if (r) begin
            m_phase = 0; m_voted = '0; m_yes = 0; m_open = 0; m_result = 3'b000;
        end else begin
            case (m_phase)
                0, 3: if (s) begin
                    m_phase = 1; m_voted = '0; m_yes = 0; m_open = 0; m_result = 3'b000;
                end
                1: begin
                    for (int i = 0; i < N; i++)
                        if (vv[i] && !m_voted[i]) begin
                            m_voted[i] = 1'b1;
                            m_yes += int'(vy[i]);
                        end
                    m_open++;
                    if (m_voted == '1 || c || m_open == TO) m_phase = 2;
                end
                2: begin
                    m_phase = 3;
                    m_done  = 1'b1;
                    if (2 * m_yes < N)       m_result = 3'b100;
                    else if (2 * m_yes == N) m_result = 3'b010;
                    else                     m_result = 3'b001;
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic check_all();
        chk("voted",        int'(voted),        int'(m_voted));
        chk("yes_count",    int'(yes_count),    m_yes);
        chk("busy",         int'(busy),         int'(m_phase == 1 || m_phase == 2));
        chk("result",       int'(result),       int'(m_result));
        chk("result_valid", int'(result_valid), int'(m_phase == 3));
        chk("done",         int'(done),         int'(m_done));
    endtask

    task automatic tick(input bit r, input bit s, input bit c,
                        input bit [N-1:0] vv, input bit [N-1:0] vy);
        rst = r; start = s; close = c; vote_valid = vv; vote_yes = vy;
        @(posedge clk);
        model_step(r, s, c, vv, vy);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, '0, '0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; close = 1'b0; vote_valid = '0; vote_yes = '0;
        tick(1, 0, 0, '0, '0);
        tick(1, 1, 1, '1, '1);
        idle(2);

        // all vote in one cycle
        tick(0, 1, 0, '0, '0);
        tick(0, 0, 0, 4'b1111, 4'b0111);
        idle(3);
        chk("plan1_result", int'(result), 3'b001);

        // tie over several cycles, starting from RESULT
        tick(0, 1, 0, '0, '0);
        tick(0, 0, 0, 4'b0101, 4'b0101);
        idle(1);
        tick(0, 0, 0, 4'b1010, 4'b0000);
        idle(3);
        chk("plan2_result", int'(result), 3'b010);

        // repeat votes ignored
        tick(0, 1, 0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            tick(0, 0, 0, 4'b0001, 4'b0001);
            idle(1);
        end
        tick(0, 0, 0, 4'b0001, 4'b0000);
        tick(0, 0, 1, '0, '0);
        idle(3);
        chk("plan3_result", int'(result), 3'b100);

        // timeout with one yes vote
        tick(0, 1, 0, '0, '0);
        tick(0, 0, 0, 4'b0010, 4'b0010);
        idle(TO + 2);
        chk("plan4_voted", int'(voted), 4'b0010);

        // timeout with the vote landing in the last OPEN cycle
        tick(0, 1, 0, '0, '0);
        tick(0, 0, 0, 4'b0111, 4'b0011);
        idle(TO - 2);
        tick(0, 0, 0, 4'b1000, 4'b1000);
        idle(3);
        chk("plan4b_yes", int'(yes_count), 3);

        // reset mid-session, then start; start while OPEN is ignored
        tick(0, 1, 0, '0, '0);
        tick(0, 0, 0, 4'b0011, 4'b0011);
        tick(1, 0, 0, '0, '0);
        tick(0, 1, 0, '0, '0);
        chk("plan5_yes", int'(yes_count), 0);
        tick(0, 0, 0, 4'b0100, 4'b0100);
        tick(0, 1, 0, '0, '0);
        tick(0, 0, 1, '0, '0);
        idle(2);

        // random traffic
        for (int k = 0; k < 4000; k++) begin
            bit [N-1:0] vv;
            for (int i = 0; i < N; i++) vv[i] = ($urandom_range(0, 4) == 0);
            tick($urandom_range(0, 79) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 24) == 0, vv, N'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
